// File: rtl/i2s_rx_deser.sv
// I2S receiver: synchronises lrck/sclk/sdat to clk, deserialises left/right words and
// presents them as a pair with a one-clk valid. Define I2S_RX_FRAME_CHECK_EN for slot-length checking.
module i2s_rx_deser #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lrck,
  input  logic                  sclk,
  input  logic                  sdat,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(SLOT_BITS) + 1;
  localparam logic [CW-1:0] DW_LAST   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SHIFT,
    ST_PAD
  } state_t;

  state_t state_q, state_d;

  logic lrck_s1_q, lrck_s1_d, lrck_s2_q, lrck_s2_d;
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d;
  logic sdat_s1_q, sdat_s1_d, sdat_s2_q, sdat_s2_d;
  logic sclk_prev_q, sclk_prev_d;
  logic rise_q, rise_d, lrck_r_q, lrck_r_d, sdat_r_q, sdat_r_d;
  logic lrck_last_q, lrck_last_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shreg_next;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] left_data_q, left_data_d, right_data_q, right_data_d;
  logic chan_q, chan_d, left_ok_q, left_ok_d;
  logic pair_q, pair_d, valid_q, valid_d;
  logic lrck_edge, slot_start;

  // Edge detection is registered (rise_q) and lrck/sdat are delayed alongside it,
  // so all three inputs stay phase-aligned when the FSM acts on a rise.
  assign lrck_edge  = rise_q && (lrck_r_q != lrck_last_q);
  assign slot_start = rise_q && (state_q == ST_IDLE) && lrck_last_q && !lrck_r_q;

  always_comb begin
    lrck_s1_d    = lrck;
    lrck_s2_d    = lrck_s1_q;
    sclk_s1_d    = sclk;
    sclk_s2_d    = sclk_s1_q;
    sdat_s1_d    = sdat;
    sdat_s2_d    = sdat_s1_q;
    sclk_prev_d  = sclk_s2_q;
    rise_d       = sclk_s2_q & ~sclk_prev_q;
    lrck_r_d     = lrck_s2_q;
    sdat_r_d     = sdat_s2_q;
    lrck_last_d  = lrck_last_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    chan_d       = chan_q;
    left_hold_d  = left_hold_q;
    left_ok_d    = left_ok_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    pair_d       = 1'b0;
    valid_d      = 1'b0;
    bit_cnt_inc  = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 1'b1;
    shreg_next   = {shreg_q[DATA_WIDTH-2:0], sdat_r_q};

    // The right word is still in shreg_q the cycle after it completes.
    if (pair_q) begin
      left_data_d  = left_hold_q;
      right_data_d = shreg_q;
      valid_d      = 1'b1;
    end

    if (rise_q) begin
      lrck_last_d = lrck_r_q;
      if (state_q == ST_IDLE) begin
        if (slot_start) begin
          state_d   = ST_DELAY;
          chan_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end else if (lrck_edge) begin
        // The rise revealing the edge carries the I2S delay bit and is discarded.
        // A left slot of the wrong length poisons the pair it belongs to.
        if (state_q == ST_PAD && !chan_q && bit_cnt_q != SLOT_LAST) left_ok_d = 1'b0;
        state_d   = ST_DELAY;
        chan_d    = lrck_r_q;
        bit_cnt_d = '0;
      end else begin
        case (state_q)
          ST_DELAY, ST_SHIFT: begin
            shreg_d   = shreg_next;
            bit_cnt_d = bit_cnt_inc;
            state_d   = ST_SHIFT;
            if (bit_cnt_inc == DW_LAST) begin
              state_d = ST_PAD;
              if (!chan_q) begin
                left_hold_d = shreg_next;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                pair_d    = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
          ST_PAD:  bit_cnt_d = bit_cnt_inc;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrck_s1_q    <= 1'b0;
      lrck_s2_q    <= 1'b0;
      sclk_s1_q    <= 1'b0;
      sclk_s2_q    <= 1'b0;
      sdat_s1_q    <= 1'b0;
      sdat_s2_q    <= 1'b0;
      sclk_prev_q  <= 1'b0;
      rise_q       <= 1'b0;
      lrck_r_q     <= 1'b0;
      sdat_r_q     <= 1'b0;
      lrck_last_q  <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      chan_q       <= 1'b0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      pair_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      lrck_s1_q    <= lrck_s1_d;
      lrck_s2_q    <= lrck_s2_d;
      sclk_s1_q    <= sclk_s1_d;
      sclk_s2_q    <= sclk_s2_d;
      sdat_s1_q    <= sdat_s1_d;
      sdat_s2_q    <= sdat_s2_d;
      sclk_prev_q  <= sclk_prev_d;
      rise_q       <= rise_d;
      lrck_r_q     <= lrck_r_d;
      sdat_r_q     <= sdat_r_d;
      lrck_last_q  <= lrck_last_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      chan_q       <= chan_d;
      left_hold_q  <= left_hold_d;
      left_ok_q    <= left_ok_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      pair_q       <= pair_d;
      valid_q      <= valid_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign valid      = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [CW-1:0] SLOT_FULL = CW'(SLOT_BITS);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic          frame_err_q, frame_err_d;

  // Counts every rise of a half-period, including the one that opened it.
  always_comb begin
    slot_cnt_d  = slot_cnt_q;
    frame_err_d = frame_err_q;
    if (slot_start) begin
      slot_cnt_d = CW'(1);
    end else if (rise_q && state_q != ST_IDLE) begin
      if (lrck_edge) begin
        if (slot_cnt_q != SLOT_FULL) frame_err_d = 1'b1;
        slot_cnt_d = CW'(1);
      end else if (slot_cnt_q != '1) begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: drives I2S frames (sclk = clk/4, 32-bit slots) and
// scores each valid pair against an expected queue.
module tb_i2s_rx_deser;
  localparam int DW = 24;

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lrck = 1'b0;
  logic sclk = 1'b0;
  logic sdat = 1'b0;
  logic [DW-1:0] left_data, right_data;
  logic valid, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int mark_cyc = 0;
  int last_v = -1;
  bit lat_en = 1'b0;
  bit per_en = 1'b0;
  logic vprev = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  i2s_rx_deser #(.DATA_WIDTH(DW), .SLOT_BITS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .lrck       (lrck),
    .sclk       (sclk),
    .sdat       (sdat),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  // clock / cycle counter
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every valid must match the oldest expected pair
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      check("valid_one_clk", 48'(vprev), 48'd0);
      if (exp_q.size() == 0) check("spurious_valid", 48'(valid), 48'd0);
      else check("pair", {left_data, right_data}, exp_q.pop_front());
      if (lat_en) begin
        check("latency", 48'(cyc - mark_cyc), 48'd4);
        lat_en = 1'b0;
      end
      if (per_en && last_v >= 0) check("period", 48'(cyc - last_v), 48'd256);
      last_v = cyc;
    end
    vprev = valid;
  end

  // one sclk period = 4 clk; data and lrck change while sclk falls
  task automatic sclk_cycle(input logic ws, input logic d, input bit do_rst, input bit mark);
    @(posedge clk); #1;
    sclk = 1'b0; lrck = ws; sdat = d;
    @(posedge clk); #1;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      check("rst_left", 48'(left_data), 48'd0);
      check("rst_right", 48'(right_data), 48'd0);
      check("rst_valid", 48'(valid), 48'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sclk = 1'b1;
    if (mark) begin
      mark_cyc = cyc + 1;
      lat_en = 1'b1;
    end
    @(posedge clk);
  endtask

  // slot bit 0 is the I2S delay bit, bits 1..DW the word MSB first, the rest padding
  task automatic send_slot(input logic ws, input logic [DW-1:0] w, input int nbits,
                           input logic pad, input int rst_at, input bit mark_lsb);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      d = (i >= 1 && i <= DW) ? w[DW-i] : pad;
      sclk_cycle(ws, d, i == rst_at, mark_lsb && i == DW);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic pad, input bit expect_pair);
    if (expect_pair) exp_q.push_back({l, r});
    send_slot(1'b0, l, 32, pad, -1, 1'b0);
    send_slot(1'b1, r, 32, pad, -1, 1'b0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_left", 48'(left_data), 48'd0);
    check("reset_right", 48'(right_data), 48'd0);
    check("reset_valid", 48'(valid), 48'd0);
    check("reset_frame_err", 48'(frame_err), 48'd0);
    rst = 1'b0;

    // Nominal stream, entered from a right slot; first pair also times the latency.
    send_slot(1'b1, 24'h123456, 32, 1'b0, -1, 1'b0);
    per_en = 1'b1;
    exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_slot(1'b0, 24'hA5A5A5, 32, 1'b0, -1, 1'b0);
    send_slot(1'b1, 24'h5A5A5A, 32, 1'b0, -1, 1'b1);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1);
    per_en = 1'b0;
    check("t1_valid_count", 48'(valid_cnt), 48'd3);
    check("t1_left_hold", 48'(left_data), 48'hA5A5A5);
    check("t1_right_hold", 48'(right_data), 48'h5A5A5A);

    // Extreme words with padding held high.
    send_frame(24'h800000, 24'h7FFFFF, 1'b1, 1'b1);
    check("t2_left", 48'(left_data), 48'h800000);
    check("t2_right", 48'(right_data), 48'h7FFFFF);

    // Reset, then start mid-right slot.
    pulse_rst();
    check("t3_rst_left", 48'(left_data), 48'd0);
    send_slot(1'b1, 24'hFFFFFF, 16, 1'b1, -1, 1'b0);
    check("t3_no_valid_yet", 48'(valid_cnt), 48'd4);
    send_frame(24'hC3C3C3, 24'h3C3C3C, 1'b0, 1'b1);
    check("t3_valid_count", 48'(valid_cnt), 48'd5);

    // Reset pulse during the 10th left bit.
    send_frame(24'h13579B, 24'h2468AC, 1'b0, 1'b1);
    send_slot(1'b0, 24'hDEADBE, 32, 1'b0, 10, 1'b0);
    send_slot(1'b1, 24'hBEEF00, 32, 1'b0, -1, 1'b0);
    check("t4_no_valid_after_rst", 48'(valid_cnt), 48'd6);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1, 1'b1);
    check("t4_valid_count", 48'(valid_cnt), 48'd7);

    // Left slot shortened to 30 sclk: the pair is dropped.
    check("t5_frame_err_before", 48'(frame_err), 48'd0);
    send_slot(1'b0, 24'h654321, 30, 1'b0, -1, 1'b0);
    send_slot(1'b1, 24'h000001, 32, 1'b0, -1, 1'b0);
    check("t5_no_valid", 48'(valid_cnt), 48'd7);
    check("t5_frame_err", 48'(frame_err), 48'(FE_EXP));
    send_frame(24'h00FF00, 24'hFF00FF, 1'b0, 1'b1);
    check("t5_recover_count", 48'(valid_cnt), 48'd8);
    check("t5_frame_err_sticky", 48'(frame_err), 48'(FE_EXP));
    pulse_rst();
    check("t5_frame_err_cleared", 48'(frame_err), 48'd0);

    repeat (8) @(posedge clk);
    check("exp_q_drained", 48'(exp_q.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
